// File: rtl/m92_pic_pkg.sv
// rtl/m92_pic_pkg.sv - shared types and constants for the m92 nested interrupt controller
package m92_pic_pkg;

   typedef enum logic [2:0] {
      UNINIT,
      INIT_IW2,
      INIT_IW3,
      INIT_IW4,
      READY
   } init_state_t;

   typedef enum logic {
      RSEL_IRR,
      RSEL_ISR
   } rsel_t;

   localparam logic [1:0] RD_CODE_IRR = 2'b10;
   localparam logic [1:0] RD_CODE_ISR = 2'b11;

   // a0=0 write decode and command bits
   localparam int IW1_BIT  = 4;
   localparam int OCW3_BIT = 3;
   localparam int EOI_BIT  = 5;
   localparam int SL_BIT   = 6;
   localparam int ROT_BIT  = 7;

   // init word option bits
   localparam int IW1_IC4  = 0;
   localparam int IW1_SNGL = 1;
   localparam int IW1_LTIM = 3;
   localparam int IW4_AEOI = 1;

   // 0 is the highest priority; the level just above the rotation base ranks first
   function automatic logic [2:0] prio_rank(input logic [2:0] idx, input logic [2:0] base,
                                            input int n);
      logic [3:0] r;
      r = {1'b0, idx} + 4'(n) - {1'b0, base} - 4'd1;
      if (r >= 4'(n)) r = r - 4'(n);
      return r[2:0];
   endfunction

endpackage

// File: rtl/m92_pic_prio.sv
// rtl/m92_pic_prio.sv - rotating-priority resolver: highest set bit of vec, level base+1 first
module m92_pic_prio #(
   parameter int N_IRQ = 8
) (
   input  logic [N_IRQ-1:0] vec,
   input  logic [2:0]       base,
   output logic             valid,
   output logic [2:0]       idx
);

   logic [7:0] vec8;
   logic [3:0] pos;

   always_comb begin
      vec8 = '0;
      vec8[N_IRQ-1:0] = vec;
      valid = 1'b0;
      idx = '0;
      pos = '0;
      // walk from lowest to highest priority so the last hit is the winner
      for (int k = N_IRQ - 1; k >= 0; k--) begin
         pos = {1'b0, base} + 4'(k) + 4'd1;
         if (pos >= 4'(N_IRQ)) pos = pos - 4'(N_IRQ);
         if (vec8[pos[2:0]]) begin
            valid = 1'b1;
            idx = pos[2:0];
         end
      end
   end

endmodule

// File: rtl/m92_pic_nested.sv
// rtl/m92_pic_nested.sv - fully nested programmable interrupt controller with init word sequence
module m92_pic_nested
   import m92_pic_pkg::*;
#(
   parameter int N_IRQ     = 8,
   parameter bit ROTATE_EN = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ce,
   input  logic             cs,
   input  logic             wr,
   input  logic             rd,
   input  logic             a0,
   input  logic [7:0]       din,
   output logic [7:0]       dout,
   output logic             int_req,
   output logic [8:0]       int_vector,
   input  logic             int_ack,
   input  logic [N_IRQ-1:0] intp
);

   init_state_t      state, state_n;
   rsel_t            rsel, rsel_n;
   logic [7:0]       iw1, iw1_n, iw2, iw2_n, iw3, iw3_n, iw4, iw4_n;
   logic [N_IRQ-1:0] imw, imw_n, irr, irr_n, isr, isr_n, prev, pend, ack_mask, rd_vec;
   logic [2:0]       rot_base, rot_base_n, int_idx, int_idx_n;
   logic             int_req_n;
   logic [8:0]       int_vector_n;

   logic             cand_valid, isr_valid, cand_ok, wr_en, ack;
   logic [2:0]       cand_idx, isr_idx, lvl;

   assign pend     = irr & ~imw;
   assign wr_en    = cs & wr;
   assign ack      = int_ack & int_req;
   assign lvl      = din[2:0];
   assign ack_mask = N_IRQ'(1) << int_idx;

   m92_pic_prio #(.N_IRQ(N_IRQ)) u_irr_prio (
      .vec  (pend),
      .base (rot_base),
      .valid(cand_valid),
      .idx  (cand_idx)
   );

   m92_pic_prio #(.N_IRQ(N_IRQ)) u_isr_prio (
      .vec  (isr),
      .base (rot_base),
      .valid(isr_valid),
      .idx  (isr_idx)
   );

   // fully nested: a request must strictly outrank everything already in service
   assign cand_ok = cand_valid &&
      (!isr_valid || prio_rank(cand_idx, rot_base, N_IRQ) < prio_rank(isr_idx, rot_base, N_IRQ));

   always_comb begin
      state_n      = state;
      rsel_n       = rsel;
      iw1_n        = iw1;
      iw2_n        = iw2;
      iw3_n        = iw3;
      iw4_n        = iw4;
      imw_n        = imw;
      irr_n        = irr;
      isr_n        = isr;
      rot_base_n   = rot_base;
      int_req_n    = int_req;
      int_vector_n = int_vector;
      int_idx_n    = int_idx;

      if (ack) begin
         int_req_n = 1'b0;
         irr_n     = irr & ~ack_mask;
         if (!iw4[IW4_AEOI]) isr_n = isr | ack_mask;
      end else if (!int_req && cand_ok && state == READY) begin
         int_req_n    = 1'b1;
         int_vector_n = {iw2[6:3], cand_idx, 2'b00};
         int_idx_n    = cand_idx;
      end

      // a fresh edge in the acknowledge cycle re-arms the bit cleared above
      if (state == READY)
         irr_n = iw1[IW1_LTIM] ? intp : (irr_n | (intp & ~prev));

      if (wr_en) begin
         if (a0) begin
            case (state)
               INIT_IW2: begin
                  iw2_n   = din;
                  state_n = !iw1[IW1_SNGL] ? INIT_IW3 : (iw1[IW1_IC4] ? INIT_IW4 : READY);
               end
               INIT_IW3: begin
                  iw3_n   = din;
                  state_n = iw1[IW1_IC4] ? INIT_IW4 : READY;
               end
               INIT_IW4: begin
                  iw4_n   = din;
                  state_n = READY;
               end
               READY:    imw_n = din[N_IRQ-1:0];
               default:  ;
            endcase
         end else if (din[IW1_BIT]) begin
            iw1_n      = din;
            imw_n      = '0;
            irr_n      = '0;
            isr_n      = '0;
            int_req_n  = 1'b0;
            rot_base_n = 3'(N_IRQ - 1);
            state_n    = INIT_IW2;
         end else if (din[OCW3_BIT]) begin
            if (din[1:0] == RD_CODE_IRR) rsel_n = RSEL_IRR;
            else if (din[1:0] == RD_CODE_ISR) rsel_n = RSEL_ISR;
         end else if (state == READY && din[EOI_BIT]) begin
            if (din[SL_BIT]) begin
               if (int'(lvl) < N_IRQ) begin
                  isr_n = isr_n & ~(N_IRQ'(1) << lvl);
                  if (ROTATE_EN && din[ROT_BIT]) rot_base_n = lvl;
               end
            end else if (isr_valid) begin
               isr_n = isr_n & ~(N_IRQ'(1) << isr_idx);
               if (ROTATE_EN && din[ROT_BIT]) rot_base_n = isr_idx;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= UNINIT;
         rsel       <= RSEL_IRR;
         iw1        <= '0;
         iw2        <= '0;
         iw3        <= '0;
         iw4        <= '0;
         imw        <= '0;
         irr        <= '0;
         isr        <= '0;
         prev       <= '0;
         rot_base   <= 3'(N_IRQ - 1);
         int_req    <= 1'b0;
         int_vector <= '0;
         int_idx    <= '0;
      end else if (ce) begin
         state      <= state_n;
         rsel       <= rsel_n;
         iw1        <= iw1_n;
         iw2        <= iw2_n;
         iw3        <= iw3_n;
         iw4        <= iw4_n;
         imw        <= imw_n;
         irr        <= irr_n;
         isr        <= isr_n;
         prev       <= intp;
         rot_base   <= rot_base_n;
         int_req    <= int_req_n;
         int_vector <= int_vector_n;
         int_idx    <= int_idx_n;
      end
   end

   always_comb begin
      rd_vec = a0 ? imw : ((rsel == RSEL_ISR) ? isr : irr);
      dout = '0;
      dout[N_IRQ-1:0] = rd_vec;
   end

   logic unused_bits;
   assign unused_bits = ^{rd, iw3, iw1[7:4], iw1[2], iw2[7], iw2[2:0], iw4[7:2], iw4[0]};

endmodule

// File: doc/m92_pic_nested.md
M92_PIC_NESTED -- requirements
Module: m92_pic_nested

Interface
REQ-001 SHALL have parameter N_IRQ, default 8, number of request inputs (legal 1..8).
REQ-002 SHALL have parameter ROTATE_EN, default 0; when 1, rotating-priority commands are honoured.
REQ-003 SHALL have ports: clk input 1 clock; reset input 1 asynchronous, active-high.
REQ-004 SHALL have ports: ce input 1 clock enable; cs input 1 chip select; wr input 1 write strobe; rd input 1 read strobe; a0 input 1 register select.
REQ-005 SHALL have ports: din input 8 write data; dout output 8 read data.
REQ-006 SHALL have ports: int_req output 1 CPU request; int_vector output 9 vector; int_ack input 1 CPU acknowledge.
REQ-007 SHALL have port intp input N_IRQ request lines.

Function
REQ-008 All state SHALL advance only on clk edges with ce=1.
REQ-009 SHALL implement init FSM with states UNINIT, INIT_IW2, INIT_IW3, INIT_IW4, READY.
REQ-010 Write a0=0 with din[4]=1 SHALL store IW1, clear IMW/IRR/ISR/int_req/rotation base, enter INIT_IW2 from any state.
REQ-011 Write a0=1: INIT_IW2 stores IW2 and goes to INIT_IW3 if IW1[1]=0, else INIT_IW4 if IW1[0]=1, else READY; INIT_IW3 stores IW3 and goes to INIT_IW4 if IW1[0]=1, else READY; INIT_IW4 stores IW4 and goes to READY; READY stores IMW.
REQ-012 Write a0=0, din[4:3]=00 (command) SHALL act only in READY: din[5]=1 EOI; din[6]=1 specific level din[2:0], else highest-priority ISR bit; din[7]=1 with ROTATE_EN sets lowest priority to the cleared level.
REQ-013 Write a0=0, din[4:3]=01 SHALL set read select: din[1:0]=10 IRR, 11 ISR; other codes leave it unchanged; reset value IRR.
REQ-014 dout SHALL be combinational: a0=1 -> IMW; a0=0 -> IRR or ISR per read select; bits at and above N_IRQ read 0.
REQ-015 IRR bit n SHALL set on a rising edge of intp[n] (IW1[3]=0) or while intp[n]=1 (IW1[3]=1), in READY only.
REQ-016 Level-mode IRR bit SHALL clear when intp[n] falls before acknowledge.
REQ-017 Priority SHALL be fixed (0 highest) or, with rotation, lowest = rotation base, highest = base+1 modulo N_IRQ.
REQ-018 Candidate SHALL be the highest-priority bit of IRR & ~IMW, strictly higher than the highest ISR bit (fully nested).
REQ-019 With int_req=0 and a candidate present, next ce cycle SHALL assert int_req and latch int_vector = IW2[6:3]*32 + n*4.
REQ-020 int_req and int_vector SHALL hold unchanged until int_ack; IMW/IRR changes do not withdraw them.
REQ-021 On int_ack with int_req=1: clear int_req, clear IRR[n], set ISR[n] unless IW4[1]=1 (auto-EOI: ISR unchanged); next request no sooner than the following ce cycle.
REQ-022 Same-cycle new edge on intp[n] and ack of n SHALL leave IRR[n]=1.
REQ-023 EOI with ISR empty SHALL be a no-op; specific EOI on level >= N_IRQ SHALL be ignored.
REQ-024 int_ack with int_req=0 SHALL be ignored.

Reset
REQ-025 Reset SHALL force UNINIT, int_req=0, int_vector=0, IMW=IRR=ISR=0, edge latch=0, rotation base=N_IRQ-1, read select=IRR, IW1..IW4=0.
REQ-026 Reset during pending int_req SHALL drop it immediately (asynchronous).

Structure
REQ-027 Package m92_pic_pkg SHALL hold the init-state enum, command-bit position constants and read-select codes.
REQ-028 Sub-module m92_pic_prio (N_IRQ param; inputs mask vector, rotation base; outputs valid, index) SHALL be instantiated twice: IRR candidate and highest ISR.

Verification
REQ-029 Init IW1=0x13, IW2=0x40, IW4=0x00, IMW=0x00; rising intp[2] -> int_req=1, int_vector=0x108; ack -> ISR=0x04.
REQ-030 ISR[2] set; raise intp[5] -> no int_req; raise intp[0] -> int_vector=0x100; non-specific EOI twice -> ISR=0x00, then intp[5] served (0x114).
REQ-031 IMW=0x08, rising intp[3] -> no request, IRR=0x08 readable; write IMW=0x00 -> request vector 0x10C.
REQ-032 IW1=0x1B (level), pulse intp[1] low before ack -> IRR[1]=0; hold high -> request, ack, auto-EOI via IW4=0x02 keeps ISR=0x00.
REQ-033 ROTATE_EN=1, N_IRQ=4: rotate-EOI on level 1 -> simultaneous intp[1],intp[2] serves 2 first.
REQ-034 Assert reset while int_req=1 -> int_req=0 same cycle, state UNINIT, intp edges ignored until reinit.
